pwm_capture_mc: RTL and testbench
=================================

PWM_CAPTURE_MC -- requirements
Module: pwm_capture_mc

Interface
REQ-001 Parameter NCH, default 3: number of independent PWM channels (1..16).
REQ-002 Parameter DW, default 32: width of each count result (8..32).
REQ-003 Parameter SYNC_STAGES, default 2: input synchroniser depth (2..4).
REQ-004 Parameter TIMEOUT, default 5_000_000: cycles without an edge before a channel is flagged stuck (1 < TIMEOUT < 2^DW).
REQ-005 clk  input  1  single system clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pwm_in  input  NCH  asynchronous PWM inputs; bit i is channel i.
REQ-008 high_count  output  NCH*DW  last complete high time per channel, in cycles; slice [i*DW +: DW].
REQ-009 low_count  output  NCH*DW  last complete low time per channel, in cycles; same slicing.
REQ-010 meas_valid  output  NCH  one-cycle pulse when channel i publishes a new high/low pair.
REQ-011 stuck  output  NCH  channel i has seen no edge for TIMEOUT cycles.
REQ-012 level  output  NCH  synchronised current level of each input.

Function
REQ-013 Each channel SHALL pass pwm_in[i] through SYNC_STAGES flops; s = last stage, p = s delayed one cycle; rise = s&~p, fall = ~s&p.
REQ-014 Per channel a DW-bit counter SHALL load 1 on any edge cycle, else increment, saturating at 2^DW-1.
REQ-015 A synchronised phase of N cycles SHALL measure exactly N.
REQ-016 Per-channel FSM states: ARM, HIGH, LOW.
REQ-017 ARM: on rise -> HIGH; falls ignored.
REQ-018 HIGH: on fall -> LOW, capture counter into an internal high latch.
REQ-019 LOW: on rise -> HIGH, update high_count from the latch and low_count from the counter atomically, and assert meas_valid on the next cycle.
REQ-020 The first pair after reset or after a stuck event SHALL be published only after a complete rise-fall-rise sequence; partial phases SHALL never be published.
REQ-021 Outputs SHALL be registered; pin-to-meas_valid latency SHALL be SYNC_STAGES+1 cycles after the rise reaches the pin.
REQ-022 In HIGH or LOW, when the counter equals TIMEOUT, stuck[i] SHALL be set and the FSM SHALL go to ARM; high_count/low_count SHALL hold their last values.
REQ-023 stuck[i] SHALL clear on the next edge of channel i.
REQ-024 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each be handled in the same cycle.
REQ-025 An edge in the same cycle the counter reaches TIMEOUT SHALL take priority: the edge is processed and stuck is not set.
REQ-026 level[i] SHALL equal s for channel i.

Reset
REQ-027 While reset=1, high_count, low_count, meas_valid and stuck SHALL be 0, counters 0, FSMs ARM, and synchroniser and p flops 0.
REQ-028 Reset asserted mid-measurement SHALL discard all partial data; the first meas_valid after release requires a full sequence per REQ-020.

Structure
REQ-029 Package pwm_pkg SHALL hold the FSM state encoding (ARM/HIGH/LOW) and the parameter-range constants.
REQ-030 Sub-module pwm_chan (one channel: synchroniser, counter, FSM, output regs) SHALL be instantiated NCH times via generate.

Verification
Bench: NCH=3, DW=16, SYNC_STAGES=2, TIMEOUT=1000.
REQ-031 Ch0 square wave 7 high / 3 low -> from the second period on, meas_valid[0] pulses every 10 cycles with high=7, low=3.
REQ-032 Ch0=7/3, ch1=1/1, ch2=50/150 concurrently -> correct independent pairs (1/1, 50/150); no cross-talk.
REQ-033 Ch0 held high for 1200 cycles -> stuck[0] rises on the counter=1000 cycle, counts unchanged; next fall clears stuck and no meas_valid until rise-fall-rise completes.
REQ-034 Input high at reset release -> first meas_valid only after a full subsequent low and high phase; no partial values published.
REQ-035 Reset asserted mid-HIGH, then 4/6 wave -> outputs 0 during reset, first pulse reports high=4, low=6.
REQ-036 Edge arriving on the TIMEOUT cycle -> stuck stays 0 and the FSM advances.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM capture block: channel FSM
// encoding and the legal parameter ranges.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_ARM  = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

  localparam int NCH_MIN  = 1;
  localparam int NCH_MAX  = 16;
  localparam int DW_MIN   = 8;
  localparam int DW_MAX   = 32;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;

  function automatic bit params_ok(input int nch, input int dw, input int sync_stages,
                                   input longint timeout);
    return (nch >= NCH_MIN) && (nch <= NCH_MAX) &&
           (dw >= DW_MIN) && (dw <= DW_MAX) &&
           (sync_stages >= SYNC_MIN) && (sync_stages <= SYNC_MAX) &&
           (timeout > 1) && (timeout < (longint'(1) << dw));
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM capture channel: input synchroniser, phase counter, ARM/HIGH/LOW
// FSM and registered high/low results with stuck detection.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_ARM  | waiting for a rise; no partial phase is ever measured here
// ST_HIGH | timing the high phase that started on the last rise
// ST_LOW  | high phase latched, timing the low phase until next rise
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 5_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pwm_in,
  output logic [DW-1:0] high_count,
  output logic [DW-1:0] low_count,
  output logic          meas_valid,
  output logic          stuck,
  output logic          level
);

  localparam logic [DW-1:0] CNT_MAX     = '1;
  localparam logic [DW-1:0] TIMEOUT_CNT = DW'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic                   s;
  logic                   p;
  logic                   primed;
  logic                   rise;
  logic                   fall;
  logic                   edge_det;
  logic [DW-1:0]          cnt;
  logic [DW-1:0]          high_latch;
  pwm_state_e             state;
  pwm_state_e             state_nxt;
  logic                   cap_high;
  logic                   publish;
  logic                   set_stuck;

  assign s     = sync_q[SYNC_STAGES-1];
  assign level = s;

  // After reset the synchroniser and p hold zeros, not samples of the pin; an
  // input already high at release would otherwise look like a rise and start
  // a truncated high phase. Edges count only once p carries real data.
  assign primed   = fill_q[SYNC_STAGES];
  assign rise     = primed & s & ~p;
  assign fall     = primed & ~s & p;
  assign edge_det = rise | fall;

  always_comb begin
    state_nxt = state;
    cap_high  = 1'b0;
    publish   = 1'b0;
    set_stuck = 1'b0;
    unique case (state)
      ST_ARM: begin
        if (rise) state_nxt = ST_HIGH;
      end
      ST_HIGH: begin
        if (fall) begin
          state_nxt = ST_LOW;
          cap_high  = 1'b1;
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = ST_ARM;
          set_stuck = 1'b1;
        end
      end
      ST_LOW: begin
        if (rise) begin
          state_nxt = ST_HIGH;
          publish   = 1'b1;
        end else if (cnt == TIMEOUT_CNT) begin
          state_nxt = ST_ARM;
          set_stuck = 1'b1;
        end
      end
      default: state_nxt = ST_ARM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      fill_q     <= '0;
      p          <= 1'b0;
      state      <= ST_ARM;
      cnt        <= '0;
      high_latch <= '0;
      high_count <= '0;
      low_count  <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      p      <= s;
      state  <= state_nxt;

      // Loading 1 on the edge cycle makes an N-cycle phase read N at its end.
      if (edge_det) begin
        cnt <= DW'(1);
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + DW'(1);
      end

      if (cap_high) high_latch <= cnt;
      if (publish) begin
        high_count <= high_latch;
        low_count  <= cnt;
      end
      meas_valid <= publish;

      if (edge_det) begin
        stuck <= 1'b0;
      end else if (set_stuck) begin
        stuck <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pwm_capture_mc.sv
// Multi-channel PWM high/low time capture; each input bit is measured by an
// independent pwm_chan instance.
module pwm_capture_mc
  import pwm_pkg::*;
#(
  parameter int NCH         = 3,
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 5_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    pwm_in,
  output logic [NCH*DW-1:0] high_count,
  output logic [NCH*DW-1:0] low_count,
  output logic [NCH-1:0]    meas_valid,
  output logic [NCH-1:0]    stuck,
  output logic [NCH-1:0]    level
);

  if (!params_ok(NCH, DW, SYNC_STAGES, longint'(TIMEOUT))) begin : g_bad_params
    $error("pwm_capture_mc: parameter out of range");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    pwm_chan #(
      .DW          (DW),
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .pwm_in     (pwm_in[i]),
      .high_count (high_count[i*DW +: DW]),
      .low_count  (low_count[i*DW +: DW]),
      .meas_valid (meas_valid[i]),
      .stuck      (stuck[i]),
      .level      (level[i])
    );
  end

endmodule

// File: tb/tb_pwm_capture_mc.sv
// Scoreboard bench for pwm_capture_mc: drivers push expected high/low pairs,
// a negedge monitor pops and compares on every meas_valid pulse.
module tb_pwm_capture_mc;

  localparam int NCH         = 3;
  localparam int DW          = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 1000;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NCH-1:0]    pwm_in = '0;
  logic [NCH*DW-1:0] high_count;
  logic [NCH*DW-1:0] low_count;
  logic [NCH-1:0]    meas_valid;
  logic [NCH-1:0]    stuck;
  logic [NCH-1:0]    level;

  pwm_capture_mc #(
    .NCH         (NCH),
    .DW          (DW),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .high_count (high_count),
    .low_count  (low_count),
    .meas_valid (meas_valid),
    .stuck      (stuck),
    .level      (level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] hi;
    logic [DW-1:0] lo;
  } pair_t;

  pair_t exp_q[NCH][$];
  pair_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    gap_exp[NCH];
  int    last_pulse[NCH];
  bit    have_last[NCH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        if (meas_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            check($sformatf("unexpected_pulse_ch%0d", i), 32'd1, 32'd0);
          end else begin
            mon_e = exp_q[i].pop_front();
            check($sformatf("high_ch%0d", i), 32'(high_count[i*DW +: DW]), 32'(mon_e.hi));
            check($sformatf("low_ch%0d", i), 32'(low_count[i*DW +: DW]), 32'(mon_e.lo));
          end
          if (gap_exp[i] != 0 && have_last[i])
            check($sformatf("pulse_gap_ch%0d", i), cyc - last_pulse[i], gap_exp[i]);
          have_last[i]  = 1'b1;
          last_pulse[i] = cyc;
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int ch, input int h, input int l);
    pair_t e;
    e.hi = h[DW-1:0];
    e.lo = l[DW-1:0];
    exp_q[ch].push_back(e);
  endtask

  // Starts with a rise; publishes 'periods' pairs and leaves the pin high.
  task automatic run_wave(input int ch, input int h, input int l, input int periods,
                          input bit gap_chk);
    if (gap_chk) gap_exp[ch] = h + l;
    for (int k = 0; k < periods; k++) begin
      pwm_in[ch] = 1'b1;
      if (k > 0) push(ch, h, l);
      wait_cyc(h);
      pwm_in[ch] = 1'b0;
      wait_cyc(l);
    end
    pwm_in[ch] = 1'b1;
    push(ch, h, l);
  endtask

  task automatic do_reset(input string name);
    reset = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      gap_exp[i]   = 0;
      have_last[i] = 1'b0;
    end
    wait_cyc(3);
    check({name, "_rst_high"}, 32'(high_count != '0), 32'd0);
    check({name, "_rst_low"}, 32'(low_count != '0), 32'd0);
    check({name, "_rst_valid"}, 32'(meas_valid), 32'd0);
    check({name, "_rst_stuck"}, 32'(stuck), 32'd0);
    reset = 1'b0;
    wait_cyc(5);
  endtask

  task automatic drain(input string name);
    wait_cyc(10);
    for (int i = 0; i < NCH; i++)
      check($sformatf("%s_pending_ch%0d", name, i), exp_q[i].size(), 32'd0);
  endtask

  initial begin
    // Concurrent, independent waveforms on all channels.
    pwm_in = '0;
    do_reset("conc");
    fork
      run_wave(0, 7, 3, 6, 1'b1);
      run_wave(1, 1, 1, 30, 1'b1);
      run_wave(2, 50, 150, 2, 1'b1);
    join
    drain("conc");

    // Stuck high: flag on the timeout cycle, results held, rearm needs full sequence.
    pwm_in = '0;
    do_reset("stuck");
    run_wave(0, 7, 3, 2, 1'b0);
    wait_cyc(1002);
    check("stuck0_before_timeout", 32'(stuck[0]), 32'd0);
    wait_cyc(1);
    check("stuck0_at_timeout", 32'(stuck[0]), 32'd1);
    check("stuck_no_crosstalk", 32'(stuck[2:1]), 32'd0);
    check("level0_high", 32'(level[0]), 32'd1);
    wait_cyc(197);
    check("stuck_hold_high", 32'(high_count[0 +: DW]), 32'd7);
    check("stuck_hold_low", 32'(low_count[0 +: DW]), 32'd3);
    pwm_in[0] = 1'b0;
    wait_cyc(2);
    check("stuck0_until_fall", 32'(stuck[0]), 32'd1);
    wait_cyc(1);
    check("stuck0_cleared", 32'(stuck[0]), 32'd0);
    wait_cyc(1);
    pwm_in[0] = 1'b1;
    wait_cyc(5);
    pwm_in[0] = 1'b0;
    wait_cyc(4);
    pwm_in[0] = 1'b1;
    push(0, 5, 4);
    drain("stuck");

    // Input already high at reset release: truncated high phase is discarded.
    pwm_in = 3'b010;
    do_reset("hi_at_rst");
    wait_cyc(8);
    pwm_in[1] = 1'b0;
    wait_cyc(6);
    pwm_in[1] = 1'b1;
    wait_cyc(9);
    pwm_in[1] = 1'b0;
    wait_cyc(2);
    pwm_in[1] = 1'b1;
    push(1, 9, 2);
    drain("hi_at_rst");

    // Reset in the middle of a high phase, then a 4/6 wave.
    pwm_in = '0;
    do_reset("mid_rst");
    run_wave(2, 12, 8, 1, 1'b0);
    wait_cyc(10);
    check("mid_rst_pre_high", 32'(high_count[2*DW +: DW]), 32'd12);
    do_reset("mid_rst2");
    wait_cyc(3);
    pwm_in[2] = 1'b0;
    wait_cyc(6);
    run_wave(2, 4, 6, 1, 1'b0);
    drain("mid_rst");

    // Edge exactly on the timeout cycle wins; one cycle longer trips stuck.
    pwm_in = '0;
    do_reset("edge_to");
    pwm_in[2] = 1'b1;
    wait_cyc(1000);
    pwm_in[2] = 1'b0;
    wait_cyc(2);
    check("edge_on_timeout_stuck", 32'(stuck[2]), 32'd0);
    wait_cyc(3);
    pwm_in[2] = 1'b1;
    push(2, 1000, 5);
    wait_cyc(2);
    check("latency_not_early", 32'(meas_valid[2]), 32'd0);
    wait_cyc(1);
    check("latency_pulse", 32'(meas_valid[2]), 32'd1);
    wait_cyc(998);
    pwm_in[2] = 1'b0;
    wait_cyc(2);
    check("timeout_plus1_stuck", 32'(stuck[2]), 32'd1);
    wait_cyc(1);
    check("timeout_plus1_cleared", 32'(stuck[2]), 32'd0);
    check("timeout_plus1_hold", 32'(high_count[2*DW +: DW]), 32'd1000);
    drain("edge_to");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
